// File: rtl/ipml_fifo_sync_pkg.sv
// Shared definitions for the single-clock FIFO: mode encodings, flag reset
// values and the level-counter width helper.
package ipml_fifo_sync_pkg;

    localparam bit MODE_STD  = 1'b0;
    localparam bit MODE_FWFT = 1'b1;

    localparam logic RST_FULL         = 1'b0;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_OVERFLOW     = 1'b0;
    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_UNDERFLOW    = 1'b0;

    // One extra bit so that a completely full FIFO is distinguishable from empty.
    function automatic int level_width(input int depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/ipml_fifo_sync_ram.sv
// Simple-dual-port storage array with a registered, enabled read port.
// The array has no reset so it maps onto block RAM.
module ipml_fifo_sync_ram
    import ipml_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [DEPTH_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [DEPTH_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << DEPTH_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ipml_fifo_sync_v2_0.sv
// Single-clock FIFO with optional first-word-fall-through output stage,
// synchronous flush, registered level-derived flags and error pulses.
module ipml_fifo_sync_v2_0
    import ipml_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 10,
    parameter int FWFT_EN          = 0,
    parameter int ALMOST_FULL_NUM  = (1 << DEPTH_WIDTH) - 4,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   almost_full,
    output logic                   overflow,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   empty,
    output logic                   almost_empty,
    output logic                   underflow,
    output logic [DEPTH_WIDTH:0]   water_level
);

    localparam int            LW       = level_width(DEPTH_WIDTH);
    localparam bit            IS_FWFT  = (FWFT_EN != int'(MODE_STD));
    localparam logic [LW-1:0] CAPACITY = LW'(1 << DEPTH_WIDTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_LVL   = LW'(ALMOST_EMPTY_NUM);
    localparam logic [LW-1:0] ONE      = LW'(1);

    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [LW-1:0]          level;
    logic [LW-1:0]          lvl_nx;
    logic [LW-1:0]          in_flight;
    logic [DATA_WIDTH-1:0]  ram_q;
    logic                   data_zero;
    logic                   ram_q_vld;
    logic                   out_valid;
    logic                   out_valid_nx;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   ram_rd;
    logic                   load_out;

    ipml_fifo_sync_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // In FWFT mode the RAM feeds a two-deep pipe (RAM output register, then
    // out_data); a fetch is issued only when the RAM output register is free
    // or is being moved into out_data on the same edge.
    always_comb begin
        wr_acc       = wr_en && !full && !clr;
        rd_acc       = rd_en && !empty && !clr;
        in_flight    = LW'(ram_q_vld) + LW'(out_valid);
        load_out     = 1'b0;
        ram_rd       = rd_acc;
        out_valid_nx = 1'b0;
        if (IS_FWFT) begin
            load_out     = ram_q_vld && (!out_valid || rd_acc) && !clr;
            ram_rd       = !clr && (level > in_flight) && (!ram_q_vld || load_out);
            out_valid_nx = load_out || (out_valid && !rd_acc);
        end
        lvl_nx = level;
        if (wr_acc && !rd_acc) begin
            lvl_nx = level + ONE;
        end else if (!wr_acc && rd_acc) begin
            lvl_nx = level - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= RST_FULL;
            almost_full  <= RST_ALMOST_FULL;
            overflow     <= RST_OVERFLOW;
            empty        <= RST_EMPTY;
            almost_empty <= RST_ALMOST_EMPTY;
            underflow    <= RST_UNDERFLOW;
            data_zero    <= 1'b1;
            ram_q_vld    <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= RST_FULL;
            almost_full  <= RST_ALMOST_FULL;
            overflow     <= RST_OVERFLOW;
            empty        <= RST_EMPTY;
            almost_empty <= RST_ALMOST_EMPTY;
            underflow    <= RST_UNDERFLOW;
            data_zero    <= 1'b1;
            ram_q_vld    <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level        <= lvl_nx;
            full         <= (lvl_nx == CAPACITY);
            almost_full  <= (lvl_nx >= AF_LVL);
            almost_empty <= (lvl_nx <= AE_LVL);
            empty        <= IS_FWFT ? !out_valid_nx : (lvl_nx == '0);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
            if (rd_acc) begin
                data_zero <= 1'b0;
            end
            ram_q_vld <= IS_FWFT && (ram_rd || (ram_q_vld && !load_out));
            out_valid <= out_valid_nx;
            if (load_out) begin
                out_data <= ram_q;
            end
        end
    end

    // Standard mode shows zero until the first read after reset or flush.
    assign rd_data     = IS_FWFT ? out_data : (data_zero ? '0 : ram_q);
    assign water_level = level;

endmodule

// File: tb/tb_ipml_fifo_sync_v2_0.sv
// Bench for ipml_fifo_sync_v2_0: one standard-mode and one FWFT instance,
// checked against queue-based reference models.
module tb_ipml_fifo_sync_v2_0;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int AF  = 12;
    localparam int AE  = 2;
    localparam int CAP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;

    logic          s_clr = 0, s_wr = 0, s_rd = 0;
    logic [DW-1:0] s_wd = '0;
    logic          s_full, s_af, s_ov, s_empty, s_ae, s_un;
    logic [DW-1:0] s_rdata;
    logic [AW:0]   s_lvl;

    logic          f_clr = 0, f_wr = 0, f_rd = 0;
    logic [DW-1:0] f_wd = '0;
    logic          f_full, f_af, f_ov, f_empty, f_ae, f_un;
    logic [DW-1:0] f_rdata;
    logic [AW:0]   f_lvl;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sq[$];
    logic [DW-1:0] s_exp_rd = '0;
    logic          s_exp_ov = 0, s_exp_un = 0;
    logic [DW-1:0] fq[$];
    logic          f_exp_ov = 0;

    ipml_fifo_sync_v2_0 #(
        .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_EN(0),
        .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .wr_data(s_wd), .wr_en(s_wr),
        .full(s_full), .almost_full(s_af), .overflow(s_ov), .rd_en(s_rd),
        .rd_data(s_rdata), .empty(s_empty), .almost_empty(s_ae),
        .underflow(s_un), .water_level(s_lvl)
    );

    ipml_fifo_sync_v2_0 #(
        .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_EN(1),
        .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_data(f_wd), .wr_en(f_wr),
        .full(f_full), .almost_full(f_af), .overflow(f_ov), .rd_en(f_rd),
        .rd_data(f_rdata), .empty(f_empty), .almost_empty(f_ae),
        .underflow(f_un), .water_level(f_lvl)
    );

    // Standard-mode model: queue of held words plus last read word.
    task automatic s_drive(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
        logic full_m, empty_m;
        s_wr = wr; s_wd = wd; s_rd = rd; s_clr = clr;
        full_m  = (sq.size() == CAP);
        empty_m = (sq.size() == 0);
        @(posedge clk);
        if (clr) begin
            sq.delete();
            s_exp_rd = '0; s_exp_ov = 0; s_exp_un = 0;
        end else begin
            s_exp_ov = wr && full_m;
            s_exp_un = rd && empty_m;
            if (rd && !empty_m) s_exp_rd = sq.pop_front();
            if (wr && !full_m) sq.push_back(wd);
        end
        #1;
        s_wr = 0; s_rd = 0; s_clr = 0;
    endtask

    // FWFT model: queue of all held words; a pop happens when the consumer sees a word.
    task automatic f_drive(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
        logic full_m, pop;
        logic [DW-1:0] tmp;
        f_wr = wr; f_wd = wd; f_rd = rd; f_clr = clr;
        full_m = (fq.size() == CAP);
        pop    = rd && !f_empty && !clr;
        @(posedge clk);
        if (clr) begin
            fq.delete();
            f_exp_ov = 0;
        end else begin
            f_exp_ov = wr && full_m;
            if (pop) tmp = fq.pop_front();
            if (wr && !full_m) fq.push_back(wd);
        end
        #1;
        f_wr = 0; f_rd = 0; f_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({s_full, s_af, s_ov, s_empty, s_ae, s_un} !== 6'b000110)
            $display("FAIL reset_std_flags: got %b expected 000110", {s_full, s_af, s_ov, s_empty, s_ae, s_un});
        checks++; if (s_lvl !== '0) $display("FAIL reset_std_level: got %0d expected 0", s_lvl);
        checks++; if (s_rdata !== '0) $display("FAIL reset_std_rdata: got %0h expected 0", s_rdata);
        checks++; if ({f_full, f_af, f_ov, f_empty, f_ae, f_un} !== 6'b000110)
            $display("FAIL reset_fwft_flags: got %b expected 000110", {f_full, f_af, f_ov, f_empty, f_ae, f_un});
        checks++; if (f_lvl !== '0) $display("FAIL reset_fwft_level: got %0d expected 0", f_lvl);
        checks++; if (f_rdata !== '0) $display("FAIL reset_fwft_rdata: got %0h expected 0", f_rdata);
        failures += (s_full !== 0 || s_af !== 0 || s_ov !== 0 || s_empty !== 1 || s_ae !== 1 || s_un !== 0) ? 1 : 0;
        failures += (s_lvl !== '0) ? 1 : 0;
        failures += (s_rdata !== '0) ? 1 : 0;
        failures += (f_full !== 0 || f_af !== 0 || f_ov !== 0 || f_empty !== 1 || f_ae !== 1 || f_un !== 0) ? 1 : 0;
        failures += (f_lvl !== '0) ? 1 : 0;
        failures += (f_rdata !== '0) ? 1 : 0;
        rst_n = 1'b1;
        sq.delete(); fq.delete();
        s_exp_rd = '0; s_exp_ov = 0; s_exp_un = 0; f_exp_ov = 0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < CAP; i++) begin
            s_drive(1'b1, DW'(i), 1'b0, 1'b0);
            checks++; if (s_lvl !== 5'(i + 1)) begin failures++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, s_lvl, i + 1); end
            checks++; if (s_af !== (i + 1 >= AF)) begin failures++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, s_af, (i + 1 >= AF)); end
            checks++; if (s_full !== (i + 1 == CAP)) begin failures++; $display("FAIL fill_full[%0d]: got %b expected %b", i, s_full, (i + 1 == CAP)); end
        end
        s_drive(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (s_ov !== 1'b1) begin failures++; $display("FAIL overflow_pulse: got %b expected 1", s_ov); end
        checks++; if (s_lvl !== 5'd16) begin failures++; $display("FAIL overflow_level: got %0d expected 16", s_lvl); end
        s_drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL overflow_one_cycle: got %b expected 0", s_ov); end
        for (int i = 0; i < CAP; i++) begin
            s_drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (s_rdata !== DW'(i)) begin failures++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, s_rdata, i); end
            checks++; if (s_ae !== (CAP - 1 - i <= AE) || s_empty !== (i == CAP - 1)) begin
                failures++; $display("FAIL drain_flags[%0d]: got ae=%b empty=%b expected ae=%b empty=%b", i, s_ae, s_empty, (CAP - 1 - i <= AE), (i == CAP - 1));
            end
        end
    endtask

    task automatic test_std_read();
        for (int i = 0; i < 3; i++) s_drive(1'b1, 8'hA1 + DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s_drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (s_rdata !== 8'hA1 + DW'(i)) begin failures++; $display("FAIL std_read_data[%0d]: got %0h expected %0h", i, s_rdata, 8'hA1 + i); end
            checks++; if (s_empty !== (i == 2)) begin failures++; $display("FAIL std_read_empty[%0d]: got %b expected %b", i, s_empty, (i == 2)); end
        end
        s_drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_un !== 1'b1) begin failures++; $display("FAIL underflow_pulse: got %b expected 1", s_un); end
        checks++; if (s_rdata !== 8'hA3) begin failures++; $display("FAIL underflow_hold: got %0h expected a3", s_rdata); end
        s_drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (s_un !== 1'b0) begin failures++; $display("FAIL underflow_one_cycle: got %b expected 0", s_un); end
    endtask

    task automatic test_fwft_latency();
        f_drive(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b1) begin failures++; $display("FAIL fwft_empty_k: got %b expected 1", f_empty); end
        f_drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b1 || f_lvl !== 5'd1) begin failures++; $display("FAIL fwft_k1: got empty=%b level=%0d expected empty=1 level=1", f_empty, f_lvl); end
        f_drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b0 || f_rdata !== 8'h5A) begin failures++; $display("FAIL fwft_k2: got empty=%b data=%0h expected empty=0 data=5a", f_empty, f_rdata); end
        f_drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (f_empty !== 1'b1 || f_lvl !== '0) begin failures++; $display("FAIL fwft_pop: got empty=%b level=%0d expected empty=1 level=0", f_empty, f_lvl); end
        f_drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (f_un !== 1'b1) begin failures++; $display("FAIL fwft_underflow: got %b expected 1", f_un); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] head;
        for (int i = 0; i < CAP; i++) s_drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        head = sq[0];
        s_drive(1'b1, 8'h99, 1'b1, 1'b0);
        checks++; if (s_ov !== 1'b1 || s_lvl !== 5'd15) begin failures++; $display("FAIL std_full_both: got ov=%b level=%0d expected ov=1 level=15", s_ov, s_lvl); end
        checks++; if (s_rdata !== head) begin failures++; $display("FAIL std_full_both_data: got %0h expected %0h", s_rdata, head); end
        for (int i = 0; i < CAP - 1; i++) s_drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_rdata !== s_exp_rd || s_empty !== 1'b1) begin failures++; $display("FAIL std_full_drain: got %0h/%b expected %0h/1", s_rdata, s_empty, s_exp_rd); end
        s_drive(1'b1, 8'h77, 1'b1, 1'b0);
        checks++; if (s_un !== 1'b1 || s_lvl !== 5'd1) begin failures++; $display("FAIL std_empty_both: got un=%b level=%0d expected un=1 level=1", s_un, s_lvl); end
        s_drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_rdata !== 8'h77) begin failures++; $display("FAIL std_empty_both_data: got %0h expected 77", s_rdata); end

        for (int i = 0; i < CAP; i++) f_drive(1'b1, DW'($urandom), 1'b0, 1'b0);
        f_drive(1'b0, '0, 1'b0, 1'b0);
        f_drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (f_full !== 1'b1 || f_rdata !== fq[0]) begin failures++; $display("FAIL fwft_full: got full=%b data=%0h expected full=1 data=%0h", f_full, f_rdata, fq[0]); end
        f_drive(1'b1, 8'h99, 1'b1, 1'b0);
        checks++; if (f_ov !== 1'b1 || f_lvl !== 5'd15 || f_full !== 1'b0) begin
            failures++; $display("FAIL fwft_full_both: got ov=%b level=%0d full=%b expected ov=1 level=15 full=0", f_ov, f_lvl, f_full);
        end
        f_drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (f_lvl !== '0 || f_empty !== 1'b1) begin failures++; $display("FAIL fwft_clr_full: got level=%0d empty=%b expected 0/1", f_lvl, f_empty); end
    endtask

    task automatic test_stream_std();
        int wr_n = 0, rd_n = 0, cyc = 0;
        while ((wr_n < 40 || sq.size() > 0) && cyc < 1000) begin
            logic wr, rd;
            logic [5:0] exp_flags;
            wr = (wr_n < 40) && ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            if (wr && sq.size() < CAP) wr_n++;
            if (rd && sq.size() > 0) rd_n++;
            s_drive(wr, DW'($urandom), rd, 1'b0);
            cyc++;
            exp_flags = {sq.size() == CAP, sq.size() >= AF, s_exp_ov, sq.size() == 0, sq.size() <= AE, s_exp_un};
            checks++; if (s_rdata !== s_exp_rd) begin failures++; $display("FAIL std_stream_data[%0d]: got %0h expected %0h", cyc, s_rdata, s_exp_rd); end
            checks++; if (s_lvl !== 5'(sq.size()) || s_lvl > 5'd16) begin failures++; $display("FAIL std_stream_level[%0d]: got %0d expected %0d", cyc, s_lvl, sq.size()); end
            checks++; if ({s_full, s_af, s_ov, s_empty, s_ae, s_un} !== exp_flags) begin
                failures++; $display("FAIL std_stream_flags[%0d]: got %b expected %b", cyc, {s_full, s_af, s_ov, s_empty, s_ae, s_un}, exp_flags);
            end
        end
        checks++; if (rd_n !== 40) begin failures++; $display("FAIL std_stream_count: got %0d expected 40 (cycles %0d)", rd_n, cyc); end
    endtask

    task automatic test_stream_fwft();
        int wr_n = 0, rd_n = 0, cyc = 0, stall = 0;
        while ((wr_n < 40 || fq.size() > 0) && cyc < 1000) begin
            logic wr, rd;
            wr = (wr_n < 40) && ($urandom_range(0, 3) != 0);
            rd = !f_empty && ($urandom_range(0, 3) != 0);
            if (!f_empty) begin
                checks++; if (fq.size() == 0 || f_rdata !== fq[0]) begin failures++; $display("FAIL fwft_stream_head[%0d]: got %0h expected %0h", cyc, f_rdata, fq[0]); end
            end
            if (wr && fq.size() < CAP) wr_n++;
            if (rd) rd_n++;
            f_drive(wr, DW'($urandom), rd, 1'b0);
            cyc++;
            checks++; if (f_lvl !== 5'(fq.size()) || f_lvl > 5'd16) begin failures++; $display("FAIL fwft_stream_level[%0d]: got %0d expected %0d", cyc, f_lvl, fq.size()); end
            checks++; if ({f_full, f_af, f_ov, f_ae} !== {fq.size() == CAP, fq.size() >= AF, f_exp_ov, fq.size() <= AE}) begin
                failures++; $display("FAIL fwft_stream_flags[%0d]: got %b expected %b", cyc, {f_full, f_af, f_ov, f_ae}, {fq.size() == CAP, fq.size() >= AF, f_exp_ov, fq.size() <= AE});
            end
            stall = (f_empty && fq.size() > 0) ? stall + 1 : 0;
            checks++; if (stall > 2) begin failures++; $display("FAIL fwft_stream_stall[%0d]: got %0d empty cycles expected at most 2", cyc, stall); end
        end
        checks++; if (rd_n !== 40) begin failures++; $display("FAIL fwft_stream_count: got %0d expected 40 (cycles %0d)", rd_n, cyc); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) f_drive(1'b1, 8'h30 + DW'(i), 1'b0, 1'b0);
        repeat (3) f_drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++; if (f_empty !== 1'b0 || f_rdata !== 8'h30 + DW'(i)) begin
                failures++; $display("FAIL fwft_b2b[%0d]: got empty=%b data=%0h expected empty=0 data=%0h", i, f_empty, f_rdata, 8'h30 + i);
            end
            f_drive(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (f_empty !== 1'b1 || f_lvl !== '0) begin failures++; $display("FAIL fwft_b2b_end: got empty=%b level=%0d expected 1/0", f_empty, f_lvl); end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 10; i++) s_drive(1'b1, 8'h10 + DW'(i), 1'b0, 1'b0);
        s_drive(1'b0, '0, 1'b1, 1'b0);
        s_drive(1'b1, 8'hFF, 1'b0, 1'b1);
        checks++; if ({s_full, s_af, s_ov, s_empty, s_ae, s_un} !== 6'b000110 || s_lvl !== '0) begin
            failures++; $display("FAIL std_clr: got flags=%b level=%0d expected 000110/0", {s_full, s_af, s_ov, s_empty, s_ae, s_un}, s_lvl);
        end
        checks++; if (s_rdata !== '0) begin failures++; $display("FAIL std_clr_rdata: got %0h expected 0", s_rdata); end
        s_drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (s_lvl !== '0) begin failures++; $display("FAIL std_clr_nowrite: got %0d expected 0", s_lvl); end
        s_drive(1'b1, 8'h42, 1'b0, 1'b0);
        s_drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_rdata !== 8'h42) begin failures++; $display("FAIL std_after_clr: got %0h expected 42", s_rdata); end

        for (int i = 0; i < 9; i++) f_drive(1'b1, 8'h60 + DW'(i), 1'b0, 1'b0);
        f_drive(1'b0, '0, 1'b0, 1'b0);
        f_drive(1'b1, 8'hFF, 1'b0, 1'b1);
        checks++; if (f_lvl !== '0 || f_empty !== 1'b1 || f_rdata !== '0) begin
            failures++; $display("FAIL fwft_clr: got level=%0d empty=%b data=%0h expected 0/1/0", f_lvl, f_empty, f_rdata);
        end
        f_drive(1'b1, 8'h24, 1'b0, 1'b0);
        repeat (2) f_drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (f_empty !== 1'b0 || f_rdata !== 8'h24) begin failures++; $display("FAIL fwft_after_clr: got empty=%b data=%0h expected 0/24", f_empty, f_rdata); end
        f_drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            s_drive(1'b1, 8'hC0 + DW'(i), 1'b0, 1'b0);
            f_drive(1'b1, 8'hD0 + DW'(i), 1'b0, 1'b0);
        end
        s_drive(1'b0, '0, 1'b1, 1'b0);
        f_drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({s_full, s_af, s_ov, s_empty, s_ae, s_un} !== 6'b000110 || s_lvl !== '0 || s_rdata !== '0) begin
            failures++; $display("FAIL async_rst_std: got flags=%b level=%0d data=%0h expected 000110/0/0", {s_full, s_af, s_ov, s_empty, s_ae, s_un}, s_lvl, s_rdata);
        end
        checks++; if ({f_full, f_af, f_ov, f_empty, f_ae, f_un} !== 6'b000110 || f_lvl !== '0 || f_rdata !== '0) begin
            failures++; $display("FAIL async_rst_fwft: got flags=%b level=%0d data=%0h expected 000110/0/0", {f_full, f_af, f_ov, f_empty, f_ae, f_un}, f_lvl, f_rdata);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sq.delete(); fq.delete();
        s_exp_rd = '0; s_exp_ov = 0; s_exp_un = 0; f_exp_ov = 0;
        s_drive(1'b1, 8'h3C, 1'b0, 1'b0);
        s_drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (s_rdata !== 8'h3C || s_empty !== 1'b1) begin failures++; $display("FAIL after_async_rst: got %0h/%b expected 3c/1", s_rdata, s_empty); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_std_read();
        test_fwft_latency();
        test_simultaneous();
        test_stream_std();
        test_stream_fwft();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
